// File: rtl/adder_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package     : adder_seq_pkg
// Description : Shared types, constants and width helpers for the nibble-
//               serial adder sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_seq_pkg;

    // Width of one adder slice; the shared datapath adds this many bits per cycle.
    localparam int NIB_W = 4;

    // Sequencer states: accept operands, step through nibbles, present result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A legal operand width is a whole number of nibbles and at least two nibbles.
    function automatic bit width_legal(input int width);
        return ((width % NIB_W) == 0) && (width >= 2 * NIB_W);
    endfunction

    // Number of nibble steps for a given width; 0 flags an illegal width.
    function automatic int nib_count(input int width);
        if (width_legal(width)) begin
            return width / NIB_W;
        end
        return 0;
    endfunction

endpackage : adder_seq_pkg
`default_nettype wire

// File: rtl/four_bit_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : four_bit_full_adder
// Description : Combinational 4-bit ripple-carry full adder used as the
//               shared arithmetic slice of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module four_bit_full_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] w_carry;

    assign w_carry[0] = cin;

    // One full-adder cell per bit, carry rippling from bit 0 upwards.
    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign cout = w_carry[4];

endmodule : four_bit_full_adder
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_ctrl
// Description : Adds or subtracts WIDTH-bit operands one nibble per cycle
//               (LSB first) through a single shared 4-bit adder, with
//               valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    // Reject widths that are not a whole number of nibbles (or too narrow).
    if (!width_legal(WIDTH)) begin : g_width_check
        $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
    end

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b_eff;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic               w_last;
    logic [NIB_W-1:0]   w_add_a;
    logic [NIB_W-1:0]   w_add_b;
    logic               w_add_cin;
    logic [NIB_W-1:0]   w_add_sum;
    logic               w_add_cout;

    assign w_last    = (r_idx == IDX_W'(NIB - 1));
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

    // Feed the shared adder only while stepping; park it at zero otherwise.
    always_comb begin
        w_add_a   = '0;
        w_add_b   = '0;
        w_add_cin = 1'b0;
        if (r_state == RUN) begin
            w_add_a   = r_a[NIB_W*r_idx +: NIB_W];
            w_add_b   = r_b_eff[NIB_W*r_idx +: NIB_W];
            w_add_cin = r_carry;
        end
    end

    four_bit_full_adder u_adder (
        .a    (w_add_a),
        .b    (w_add_b),
        .cin  (w_add_cin),
        .sum  (w_add_sum),
        .cout (w_add_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: no DONE-to-RUN bypass, so results are separated by IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    // Operand capture, per-nibble result/carry update and final flag capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b_eff <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1, so cin is replaced by 1.
                        r_a     <= op_a;
                        r_b_eff <= sub ? ~op_b : op_b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_sum   <= '0;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_sum[NIB_W*r_idx +: NIB_W] <= w_add_sum;
                    r_carry                     <= w_add_cout;
                    if (w_last) begin
                        r_idx  <= '0;
                        r_cout <= w_add_cout;
                        // Signed overflow: same-sign operands yielding a different-sign result.
                        r_ovf  <= (r_a[WIDTH-1] == r_b_eff[WIDTH-1]) &&
                                  (w_add_sum[NIB_W-1] != r_a[WIDTH-1]);
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : nibble_serial_adder_ctrl
`default_nettype wire
